// File: rtl/gasket_tx.sv
// Transmit gasket: serialises 32-bit words (1, 2 or 4 symbols each) into one
// registered 8-bit symbol per clock, filling gaps with the IDLE_SYM K symbol.
module gasket_tx #(
  parameter logic [7:0] IDLE_SYM = 8'h7C
) (
  input  logic        clk_to_get,
  input  logic        Rst,
  input  logic [5:0]  width,
  input  logic [31:0] Data_in,
  input  logic [3:0]  Datak_in,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic [7:0]  Sym_Out,
  output logic        Sym_K,
  output logic        Sym_Valid,
  output logic        Word_Start,
  output logic        Underrun,
  output logic        Width_Err
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SEND = 1'b1;

  logic        state_q, state_d;
  logic [31:0] curData_q, curData_d;
  logic [3:0]  curK_q, curK_d;
  logic [2:0]  curN_q, curN_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] nxtData_q, nxtData_d;
  logic [3:0]  nxtK_q, nxtK_d;
  logic [2:0]  nxtN_q, nxtN_d;
  logic        nxtFull_q, nxtFull_d;
  logic [7:0]  symOut_q, symOut_d;
  logic        symK_q, symK_d;
  logic        symValid_q, symValid_d;
  logic        wordStart_q, wordStart_d;
  logic        underrun_q, underrun_d;
  logic        widthErr_q, widthErr_d;

  logic        accept;
  logic [2:0]  nbIn;
  logic        widthBad;
  logic [7:0]  curByte;

  assign In_Ready   = !nxtFull_q;
  assign accept     = In_Valid && In_Ready;
  assign curByte    = curData_q[{idx_q, 3'b000} +: 8];

  assign Sym_Out    = symOut_q;
  assign Sym_K      = symK_q;
  assign Sym_Valid  = symValid_q;
  assign Word_Start = wordStart_q;
  assign Underrun   = underrun_q;
  assign Width_Err  = widthErr_q;

  // Illegal widths still move one symbol so the stream never stalls.
  always_comb begin
    nbIn     = 3'd1;
    widthBad = 1'b0;
    case (width)
      6'd8:    nbIn = 3'd1;
      6'd16:   nbIn = 3'd2;
      6'd32:   nbIn = 3'd4;
      default: widthBad = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    curData_d   = curData_q;
    curK_d      = curK_q;
    curN_d      = curN_q;
    idx_d       = idx_q;
    nxtData_d   = nxtData_q;
    nxtK_d      = nxtK_q;
    nxtN_d      = nxtN_q;
    nxtFull_d   = nxtFull_q;
    symOut_d    = IDLE_SYM;
    symK_d      = 1'b1;
    symValid_d  = 1'b0;
    wordStart_d = 1'b0;
    underrun_d  = 1'b0;
    widthErr_d  = accept && widthBad;

    case (state_q)
      STATE_IDLE: begin
        // A parked word always drains first; In_Ready is low while it waits.
        if (nxtFull_q) begin
          symOut_d    = nxtData_q[7:0];
          symK_d      = nxtK_q[0];
          symValid_d  = 1'b1;
          wordStart_d = 1'b1;
          nxtFull_d   = 1'b0;
          if (nxtN_q > 3'd1) begin
            curData_d = nxtData_q;
            curK_d    = nxtK_q;
            curN_d    = nxtN_q;
            idx_d     = 2'd1;
            state_d   = STATE_SEND;
          end
        end else if (accept) begin
          symOut_d    = Data_in[7:0];
          symK_d      = Datak_in[0];
          symValid_d  = 1'b1;
          wordStart_d = 1'b1;
          if (nbIn > 3'd1) begin
            curData_d = Data_in;
            curK_d    = Datak_in;
            curN_d    = nbIn;
            idx_d     = 2'd1;
            state_d   = STATE_SEND;
          end
        end else begin
          underrun_d = symValid_q;
        end
      end
      default: begin
        symOut_d   = curByte;
        symK_d     = curK_q[idx_q];
        symValid_d = 1'b1;
        if (accept) begin
          nxtData_d = Data_in;
          nxtK_d    = Datak_in;
          nxtN_d    = nbIn;
          nxtFull_d = 1'b1;
        end
        if ({1'b0, idx_q} == curN_q - 3'd1) begin
          idx_d   = 2'd0;
          state_d = STATE_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_to_get) begin
    if (Rst) begin
      state_q     <= STATE_IDLE;
      curData_q   <= '0;
      curK_q      <= '0;
      curN_q      <= '0;
      idx_q       <= '0;
      nxtData_q   <= '0;
      nxtK_q      <= '0;
      nxtN_q      <= '0;
      nxtFull_q   <= 1'b0;
      symOut_q    <= 8'h00;
      symK_q      <= 1'b0;
      symValid_q  <= 1'b0;
      wordStart_q <= 1'b0;
      underrun_q  <= 1'b0;
      widthErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      curData_q   <= curData_d;
      curK_q      <= curK_d;
      curN_q      <= curN_d;
      idx_q       <= idx_d;
      nxtData_q   <= nxtData_d;
      nxtK_q      <= nxtK_d;
      nxtN_q      <= nxtN_d;
      nxtFull_q   <= nxtFull_d;
      symOut_q    <= symOut_d;
      symK_q      <= symK_d;
      symValid_q  <= symValid_d;
      wordStart_q <= wordStart_d;
      underrun_q  <= underrun_d;
      widthErr_q  <= widthErr_d;
    end
  end

endmodule
